// File: rtl/ctrl_pkg.sv
// Shared types and constants for the console sequencer: console modes,
// instruction opcodes, one-hot beat encoding, ALU function words and the
// decoded strobe bundle.
package ctrl_pkg;

  typedef enum logic [2:0] {
    MODE_PROG = 3'b000,
    MODE_MWR  = 3'b001,
    MODE_MRD  = 3'b010,
    MODE_RRD  = 3'b011,
    MODE_RWR  = 3'b100,
    MODE_RSV5 = 3'b101,
    MODE_RSV6 = 3'b110,
    MODE_RSV7 = 3'b111
  } mode_t;

  typedef enum logic [3:0] {
    OP_NOP = 4'b0000,
    OP_ADD = 4'b0001,
    OP_SUB = 4'b0010,
    OP_AND = 4'b0011,
    OP_INC = 4'b0100,
    OP_LD  = 4'b0101,
    OP_ST  = 4'b0110,
    OP_JC  = 4'b0111,
    OP_JZ  = 4'b1000,
    OP_JMP = 4'b1001,
    OP_STP = 4'b1110
  } op_t;

  typedef enum logic [2:0] {
    BEAT_W1 = 3'b001,
    BEAT_W2 = 3'b010,
    BEAT_W3 = 3'b100
  } beat_t;

  typedef struct packed {
    logic [3:0] s;
    logic       m;
    logic       cin;
  } alu_t;

  localparam alu_t ALU_ADD   = '{s: 4'b1001, m: 1'b0, cin: 1'b1};
  localparam alu_t ALU_SUB   = '{s: 4'b0110, m: 1'b0, cin: 1'b0};
  localparam alu_t ALU_AND   = '{s: 4'b1011, m: 1'b1, cin: 1'b0};
  localparam alu_t ALU_INC   = '{s: 4'b0000, m: 1'b0, cin: 1'b0};
  localparam alu_t ALU_PASSB = '{s: 4'b1010, m: 1'b1, cin: 1'b0};
  localparam alu_t ALU_PASSA = '{s: 4'b1111, m: 1'b1, cin: 1'b0};

  typedef struct packed {
    logic drw, pcinc, lpc, lar, pcadd, arinc, selctl, memw, stop;
    logic lir, ldz, ldc, abus, sbus, mbus;
    alu_t alu;
    logic short_cyc, long_cyc;
  } ctrl_t;

endpackage

// File: rtl/console_seq_ctrl_beat_gen.sv
// Beat generator: owns the one-hot beat w, short/long beat skipping and the
// stop/start hold. adv is high on edges where the sequence really advances.
module beat_gen
  import ctrl_pkg::*;
(
  input  logic       t3,
  input  logic       clr,
  input  logic       restart,
  input  logic       short_cyc,
  input  logic       long_cyc,
  input  logic       stop,
  input  logic       start,
  output logic [3:1] w,
  output logic       halted,
  output logic       adv
);

  beat_t beat;
  beat_t beat_nxt;

  assign w   = beat;
  assign adv = !restart && !halted;

  // Next beat: short ends in W1, W2 without long ends the cycle, W3 always ends.
  always_comb begin
    beat_nxt = BEAT_W1;
    case (beat)
      BEAT_W1: beat_nxt = short_cyc ? BEAT_W1 : BEAT_W2;
      BEAT_W2: beat_nxt = long_cyc ? BEAT_W3 : BEAT_W1;
      default: beat_nxt = BEAT_W1;
    endcase
  end

  // Beat register and halt flag; a stopping beat still advances, then holds.
  always_ff @(posedge t3 or negedge clr) begin
    if (!clr) begin
      beat   <= BEAT_W1;
      halted <= 1'b0;
    end else if (restart) begin
      beat   <= BEAT_W1;
      halted <= 1'b0;
    end else if (halted) begin
      if (start) halted <= 1'b0;
    end else begin
      beat   <= beat_nxt;
      halted <= stop;
    end
  end

endmodule

// File: rtl/console_seq_ctrl.sv
// Console sequencer top: registers console mode, phase flag st0 and register
// pair, and decodes all datapath strobes from that state plus ir/c/z.
// Optional interrupt cycle is built when CTRL_INT_EN is defined.
module console_seq_ctrl
  import ctrl_pkg::*;
#(
  parameter  int unsigned REG_CNT = 4,
  localparam int unsigned SEL_W   = $clog2(REG_CNT)
) (
  input  logic             t3,
  input  logic             clr,
  input  logic             swc,
  input  logic             swb,
  input  logic             swa,
  input  logic             start,
  input  logic [7:4]       ir,
  input  logic             c,
  input  logic             z,
`ifdef CTRL_INT_EN
  input  logic             int_req,
  input  logic             int_en_set,
  output logic             int_ack,
`endif
  output logic [3:1]       w,
  output logic             drw,
  output logic             pcinc,
  output logic             lpc,
  output logic             lar,
  output logic             pcadd,
  output logic             arinc,
  output logic             selctl,
  output logic             memw,
  output logic             stop,
  output logic             lir,
  output logic             ldz,
  output logic             ldc,
  output logic             cin,
  output logic             m,
  output logic             abus,
  output logic             sbus,
  output logic             mbus,
  output logic [3:0]       s,
  output logic [SEL_W-1:0] rd_sel,
  output logic [SEL_W-1:0] rs_sel,
  output logic             st0
);

  localparam int unsigned PAIR_W = SEL_W - 1;

  mode_t             mode;
  mode_t             sw_mode;
  op_t               op;
  logic              run;
  logic [PAIR_W-1:0] pair;
  logic              halted;
  logic              adv;
  logic              restart;
  logic              active;
  ctrl_t             dec;
  logic [SEL_W-1:0]  rd_dec;
  logic [SEL_W-1:0]  rs_dec;
`ifdef CTRL_INT_EN
  logic              intc;
  logic              ie;
  logic              int_dec;
  logic              last_beat;
`endif

  assign sw_mode = mode_t'({swc, swb, swa});
  assign op      = op_t'(ir);
  // run stays low until the first t3 after reset, so that edge opens W1/st0=0
  assign restart = !run || (mode != sw_mode);
  assign active  = run && !halted;

  beat_gen u_beat (
    .t3        (t3),
    .clr       (clr),
    .restart   (restart),
    .short_cyc (dec.short_cyc),
    .long_cyc  (dec.long_cyc),
    .stop      (dec.stop),
    .start     (start),
    .w         (w),
    .halted    (halted),
    .adv       (adv)
  );

  // Strobe decode from mode, phase, pair and beat.
  always_comb begin
    dec    = '0;
    rd_dec = '0;
    rs_dec = '0;
`ifdef CTRL_INT_EN
    int_dec = 1'b0;
`endif
    case (mode)
      MODE_RWR: begin
        dec.short_cyc = 1'b1;
        if (w == BEAT_W1) begin
          dec.sbus   = 1'b1;
          dec.drw    = 1'b1;
          dec.selctl = 1'b1;
          dec.stop   = 1'b1;
          rd_dec     = {pair, st0};
        end
      end
      MODE_RRD: begin
        dec.short_cyc = 1'b1;
        if (w == BEAT_W1) begin
          dec.selctl = 1'b1;
          dec.stop   = 1'b1;
          rd_dec     = {pair, 1'b0};
          rs_dec     = {pair, 1'b1};
        end
      end
      MODE_MRD, MODE_MWR: begin
        dec.short_cyc = 1'b1;
        if (w == BEAT_W1) begin
          dec.selctl = 1'b1;
          dec.stop   = 1'b1;
          if (!st0) begin
            dec.sbus = 1'b1;
            dec.lar  = 1'b1;
          end else begin
            dec.arinc = 1'b1;
            if (mode == MODE_MRD) begin
              dec.mbus = 1'b1;
            end else begin
              dec.sbus = 1'b1;
              dec.memw = 1'b1;
            end
          end
        end
      end
      MODE_PROG: begin
`ifdef CTRL_INT_EN
        if (intc) begin
          int_dec       = 1'b1;
          dec.lpc       = 1'b1;
          dec.short_cyc = 1'b1;
        end else
`endif
        if (!st0) begin
          dec.short_cyc = 1'b1;
          if (w == BEAT_W1) begin
            dec.sbus = 1'b1;
            dec.lpc  = 1'b1;
            dec.stop = 1'b1;
          end
        end else begin
          case (w)
            BEAT_W1: begin
              dec.lir   = 1'b1;
              dec.pcinc = 1'b1;
            end
            BEAT_W2: begin
              case (op)
                OP_ADD: begin
                  dec.alu = ALU_ADD; dec.abus = 1'b1; dec.drw = 1'b1;
                  dec.ldz = 1'b1; dec.ldc = 1'b1;
                end
                OP_SUB: begin
                  dec.alu = ALU_SUB; dec.abus = 1'b1; dec.drw = 1'b1;
                  dec.ldz = 1'b1; dec.ldc = 1'b1;
                end
                OP_AND: begin
                  dec.alu = ALU_AND; dec.abus = 1'b1; dec.drw = 1'b1;
                  dec.ldz = 1'b1;
                end
                OP_INC: begin
                  dec.alu = ALU_INC; dec.abus = 1'b1; dec.drw = 1'b1;
                  dec.ldz = 1'b1; dec.ldc = 1'b1;
                end
                OP_LD, OP_ST: begin
                  dec.alu = ALU_PASSB; dec.abus = 1'b1; dec.lar = 1'b1;
                  dec.long_cyc = 1'b1;
                end
                OP_JC:   dec.pcadd = c;
                OP_JZ:   dec.pcadd = z;
                OP_JMP: begin
                  dec.alu = ALU_PASSA; dec.abus = 1'b1; dec.lpc = 1'b1;
                end
                OP_STP:  dec.stop = 1'b1;
                default: ;
              endcase
            end
            BEAT_W3: begin
              case (op)
                OP_LD: begin
                  dec.mbus = 1'b1; dec.drw = 1'b1;
                end
                OP_ST: begin
                  dec.alu = ALU_PASSA; dec.abus = 1'b1; dec.memw = 1'b1;
                end
                default: ;
              endcase
            end
            default: ;
          endcase
        end
      end
      default: dec.short_cyc = 1'b1;
    endcase
  end

`ifdef CTRL_INT_EN
  assign last_beat = (w == BEAT_W3) || ((w == BEAT_W2) && !dec.long_cyc);
`endif

  // Mode, phase and pair state; register write toggles st0 so that
  // {pair, st0} walks through every register one write at a time.
  always_ff @(posedge t3 or negedge clr) begin
    if (!clr) begin
      run  <= 1'b0;
      mode <= MODE_PROG;
      st0  <= 1'b0;
      pair <= '0;
`ifdef CTRL_INT_EN
      intc <= 1'b0;
      ie   <= 1'b0;
`endif
    end else begin
      if (restart) begin
        run  <= 1'b1;
        mode <= sw_mode;
        st0  <= 1'b0;
        pair <= '0;
`ifdef CTRL_INT_EN
        intc <= 1'b0;
`endif
      end else if (adv) begin
        if (w == BEAT_W1) begin
          if (mode == MODE_RWR) begin
            st0 <= ~st0;
            if (st0) pair <= pair + PAIR_W'(1);
          end else begin
            st0 <= 1'b1;
            if (mode == MODE_RRD) pair <= pair + PAIR_W'(1);
          end
        end
`ifdef CTRL_INT_EN
        if (intc) begin
          intc <= 1'b0;
        end else if ((mode == MODE_PROG) && st0 && last_beat && int_req && ie) begin
          intc <= 1'b1;
        end
`endif
      end
`ifdef CTRL_INT_EN
      if (adv && intc) begin
        ie <= 1'b0;
      end else if (int_en_set) begin
        ie <= 1'b1;
      end
`endif
    end
  end

  // Strobes only while running; a halted sequencer shows just stop.
  assign drw    = active & dec.drw;
  assign pcinc  = active & dec.pcinc;
  assign lpc    = active & dec.lpc;
  assign lar    = active & dec.lar;
  assign pcadd  = active & dec.pcadd;
  assign arinc  = active & dec.arinc;
  assign selctl = active & dec.selctl;
  assign memw   = active & dec.memw;
  assign stop   = (active & dec.stop) | halted;
  assign lir    = active & dec.lir;
  assign ldz    = active & dec.ldz;
  assign ldc    = active & dec.ldc;
  assign cin    = active & dec.alu.cin;
  assign m      = active & dec.alu.m;
  assign abus   = active & dec.abus;
  assign sbus   = active & dec.sbus;
  assign mbus   = active & dec.mbus;
  assign s      = active ? dec.alu.s : 4'b0000;
  assign rd_sel = active ? rd_dec : '0;
  assign rs_sel = active ? rs_dec : '0;
`ifdef CTRL_INT_EN
  assign int_ack = active & int_dec;
`endif

endmodule

// File: tb/tb_console_seq_ctrl.sv
// Self-checking bench for console_seq_ctrl (REG_CNT=8). Console scenarios
// are followed by a randomized instruction stream checked against a per-
// opcode beat table. Interrupt scenario is built when CTRL_INT_EN is defined.
module tb_console_seq_ctrl;

  localparam int unsigned REG_CNT = 8;
  localparam int unsigned SEL_W   = $clog2(REG_CNT);

  localparam logic [20:0] DRW    = 21'h100000;
  localparam logic [20:0] PCINC  = 21'h080000;
  localparam logic [20:0] LPC    = 21'h040000;
  localparam logic [20:0] LAR    = 21'h020000;
  localparam logic [20:0] PCADD  = 21'h010000;
  localparam logic [20:0] ARINC  = 21'h008000;
  localparam logic [20:0] SELCTL = 21'h004000;
  localparam logic [20:0] MEMW   = 21'h002000;
  localparam logic [20:0] STOP   = 21'h001000;
  localparam logic [20:0] LIR    = 21'h000800;
  localparam logic [20:0] LDZ    = 21'h000400;
  localparam logic [20:0] LDC    = 21'h000200;
  localparam logic [20:0] ABUS   = 21'h000040;
  localparam logic [20:0] SBUS   = 21'h000020;
  localparam logic [20:0] MBUS   = 21'h000010;

  logic t3 = 1'b0;
  logic clr = 1'b0;
  logic swc = 1'b0, swb = 1'b0, swa = 1'b0;
  logic start = 1'b0;
  logic [7:4] ir = 4'h0;
  logic c = 1'b0, z = 1'b0;
  logic [3:1] w;
  logic drw, pcinc, lpc, lar, pcadd, arinc, selctl, memw, stop;
  logic lir, ldz, ldc, cin, m, abus, sbus, mbus;
  logic [3:0] s;
  logic [SEL_W-1:0] rd_sel, rs_sel;
  logic st0;
  logic [20:0] obs;
`ifdef CTRL_INT_EN
  logic int_req = 1'b0, int_en_set = 1'b0, int_ack;
`endif

  int errors = 0;
  int checks = 0;

  always #5 t3 = ~t3;

  console_seq_ctrl #(.REG_CNT(REG_CNT)) dut (
    .t3(t3), .clr(clr), .swc(swc), .swb(swb), .swa(swa), .start(start),
    .ir(ir), .c(c), .z(z),
`ifdef CTRL_INT_EN
    .int_req(int_req), .int_en_set(int_en_set), .int_ack(int_ack),
`endif
    .w(w), .drw(drw), .pcinc(pcinc), .lpc(lpc), .lar(lar), .pcadd(pcadd),
    .arinc(arinc), .selctl(selctl), .memw(memw), .stop(stop), .lir(lir),
    .ldz(ldz), .ldc(ldc), .cin(cin), .m(m), .abus(abus), .sbus(sbus),
    .mbus(mbus), .s(s), .rd_sel(rd_sel), .rs_sel(rs_sel), .st0(st0)
  );

  assign obs = {drw, pcinc, lpc, lar, pcadd, arinc, selctl, memw, stop,
                lir, ldz, ldc, cin, m, abus, sbus, mbus, s};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic chk_obs(input string tag, input logic [20:0] exp);
    check(tag, 32'(obs), 32'(exp));
  endtask

  task automatic chk_w(input string tag, input logic [2:0] exp);
    check(tag, 32'(w), 32'(exp));
  endtask

  task automatic step();
    @(negedge t3);
  endtask

  // ALU word in the observed vector: cin bit8, m bit7, s bits 3:0
  function automatic logic [20:0] alu(input logic [3:0] sv, input logic mv, input logic cv);
    return {12'b0, cv, mv, 3'b000, sv};
  endfunction

  function automatic bit is_long(input logic [3:0] op);
    return (op == 4'd5) || (op == 4'd6);
  endfunction

  function automatic logic [20:0] exp_w2(input logic [3:0] op, input logic cv, input logic zv);
    case (op)
      4'd1:    return ABUS | DRW | LDZ | LDC | alu(4'b1001, 1'b0, 1'b1);
      4'd2:    return ABUS | DRW | LDZ | LDC | alu(4'b0110, 1'b0, 1'b0);
      4'd3:    return ABUS | DRW | LDZ | alu(4'b1011, 1'b1, 1'b0);
      4'd4:    return ABUS | DRW | LDZ | LDC | alu(4'b0000, 1'b0, 1'b0);
      4'd5:    return ABUS | LAR | alu(4'b1010, 1'b1, 1'b0);
      4'd6:    return ABUS | LAR | alu(4'b1010, 1'b1, 1'b0);
      4'd7:    return cv ? PCADD : 21'h0;
      4'd8:    return zv ? PCADD : 21'h0;
      4'd9:    return ABUS | LPC | alu(4'b1111, 1'b1, 1'b0);
      4'd14:   return STOP;
      default: return 21'h0;
    endcase
  endfunction

  function automatic logic [20:0] exp_w3(input logic [3:0] op);
    if (op == 4'd5) return MBUS | DRW;
    return ABUS | MEMW | alu(4'b1111, 1'b1, 1'b0);
  endfunction

  // Entered in a halted beat: verify the hold for a random dwell, then pulse start.
  task automatic resume();
    int unsigned n;
    n = $urandom_range(0, 3);
    chk_obs("halt_hold", STOP);
    chk_w("halt_w", 3'b001);
    for (int unsigned i = 0; i < n; i++) begin
      step();
      chk_obs("halt_dwell", STOP);
    end
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic set_sw(input logic [2:0] v);
    {swc, swb, swa} = v;
    step();
  endtask

  // Entered at the fetch W1 of program mode; leaves at the next fetch W1.
  task automatic run_instr(input logic [3:0] op, input logic cv, input logic zv);
    chk_obs("fetch", LIR | PCINC);
    chk_w("fetch_w", 3'b001);
`ifdef CTRL_INT_EN
    check("fetch_int_ack", 32'(int_ack), 32'd0);
`endif
    ir = op; c = cv; z = zv;
    step();
    chk_w("w2_w", 3'b010);
    chk_obs($sformatf("w2_op%0d_c%0d_z%0d", op, cv, zv), exp_w2(op, cv, zv));
    if (is_long(op)) begin
      step();
      chk_w("w3_w", 3'b100);
      chk_obs($sformatf("w3_op%0d", op), exp_w3(op));
    end
    step();
    if (op == 4'd14) resume();
  endtask

  initial begin
    // Reset
    {swc, swb, swa} = 3'b100;
    clr = 1'b0;
    repeat (2) step();
    chk_w("rst_w", 3'b001);
    chk_obs("rst_strobes", 21'h0);
    check("rst_st0", 32'(st0), 32'd0);
    check("rst_rd", 32'(rd_sel), 32'd0);
    check("rst_rs", 32'(rs_sel), 32'd0);
    clr = 1'b1;
    step();

    // Register write: every register in order, then wrap
    for (int unsigned k = 0; k < 9; k++) begin
      check($sformatf("rwr_rd_%0d", k), 32'(rd_sel), k % REG_CNT);
      chk_obs("rwr_strobes", SBUS | DRW | SELCTL | STOP);
      check("rwr_st0", 32'(st0), k % 2);
      chk_w("rwr_w", 3'b001);
      step();
      if (k < 8) resume();
    end

    // Register read: pairs in order, mode change mid-sequence
    set_sw(3'b011);
    for (int unsigned j = 0; j < 6; j++) begin
      check($sformatf("rrd_rd_%0d", j), 32'(rd_sel), 2 * (j % (REG_CNT / 2)));
      check($sformatf("rrd_rs_%0d", j), 32'(rs_sel), 2 * (j % (REG_CNT / 2)) + 1);
      chk_obs("rrd_strobes", SELCTL | STOP);
      if (j < 5) begin
        step();
        resume();
      end
    end
    set_sw(3'b010);
    check("mchg_st0", 32'(st0), 32'd0);
    chk_w("mchg_w", 3'b001);
    chk_obs("mrd_first", SBUS | LAR | SELCTL | STOP);
    step();
    resume();
    chk_obs("mrd_next", MBUS | ARINC | SELCTL | STOP);
    check("mrd_st0", 32'(st0), 32'd1);

    // Memory write
    set_sw(3'b001);
    check("mwr_st0", 32'(st0), 32'd0);
    chk_obs("mwr_first", SBUS | LAR | SELCTL | STOP);
    step();
    resume();
    chk_obs("mwr_next", SBUS | MEMW | ARINC | SELCTL | STOP);

    // Program mode: load PC, then directed instructions
    set_sw(3'b000);
    check("prog_st0", 32'(st0), 32'd0);
    chk_obs("prog_ldpc", SBUS | LPC | STOP);
    step();
    resume();
    run_instr(4'd7, 1'b0, 1'b1);
    run_instr(4'd7, 1'b1, 1'b0);
    run_instr(4'd8, 1'b1, 1'b0);
    run_instr(4'd8, 1'b0, 1'b1);
    run_instr(4'd5, 1'b0, 1'b0);
    run_instr(4'd6, 1'b0, 1'b0);
    run_instr(4'd14, 1'b0, 1'b0);
    run_instr(4'd12, 1'b0, 1'b0);

`ifdef CTRL_INT_EN
    // Interrupt after ADD, then ie cleared
    int_en_set = 1'b1;
    int_req = 1'b1;
    chk_obs("int_fetch", LIR | PCINC);
    ir = 4'd1;
    step();
    int_en_set = 1'b0;
    chk_obs("int_add_w2", exp_w2(4'd1, 1'b0, 1'b0));
    step();
    check("int_ack_cycle", 32'(int_ack), 32'd1);
    chk_obs("int_cycle", LPC);
    chk_w("int_cycle_w", 3'b001);
    step();
    run_instr(4'd1, 1'b0, 1'b0);
    check("int_ie_cleared", 32'(int_ack), 32'd0);
    chk_obs("int_after", LIR | PCINC);
    int_req = 1'b0;
`endif

    // Randomized instruction stream
    for (int unsigned i = 0; i < 60; i++) begin
      run_instr(4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    // Reset in the middle of W2
    chk_obs("abort_fetch", LIR | PCINC);
    ir = 4'd1;
    step();
    chk_w("abort_w2", 3'b010);
    clr = 1'b0;
    #1;
    chk_obs("abort_strobes", 21'h0);
    chk_w("abort_w", 3'b001);
    check("abort_st0", 32'(st0), 32'd0);
    step();
    clr = 1'b1;
    step();
    chk_w("restart_w", 3'b001);
    check("restart_st0", 32'(st0), 32'd0);
    chk_obs("restart_strobes", SBUS | LPC | STOP);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
